// File: rtl/flappy_pkg.sv
`default_nettype none
// ============================================================================
// Module      : flappy_pkg
// Description : Shared types and default constants for the flappy game blocks.
// Revision    : 1.0 - initial release
// ============================================================================
package flappy_pkg;

    // Bird motion controller states
    typedef enum logic [1:0] {
        WAIT_START = 2'd0,
        RISE       = 2'd1,
        FALL       = 2'd2,
        FROZEN     = 2'd3
    } bird_state_t;

    // 4 Hz motion tick at 50 MHz
    localparam int TICK_DIV_DEF   = 12_500_000;
    // Motion ticks of rise per accepted flap
    localparam int FLAP_TICKS_DEF = 2;
    // 20 ms of stable key level at 50 MHz
    localparam int DEB_CYCLES_DEF = 1_000_000;

endpackage : flappy_pkg
`default_nettype wire

// File: rtl/bird_motion_ctrl_if.sv
`default_nettype none
// ============================================================================
// Module      : bird_motion_ctrl_if
// Description : Key / game-state inputs and motion outputs of the bird motion
//               controller. The slave modport is the controller side, the
//               master modport is the side that drives the key and game state
//               and consumes the motion tick.
// Revision    : 1.0 - initial release
// ============================================================================
interface bird_motion_ctrl_if;

    logic key_n;      // raw flap key, active-low, asynchronous
    logic game_over;  // 1 = game ended
    logic enable;     // 1-cycle motion tick
    logic up;         // direction level, 1 = rise
    logic flap;       // 1-cycle pulse per accepted press

    modport master (
        output key_n,
        output game_over,
        input  enable,
        input  up,
        input  flap
    );

    modport slave (
        input  key_n,
        input  game_over,
        output enable,
        output up,
        output flap
    );

endinterface : bird_motion_ctrl_if
`default_nettype wire

// File: rtl/tick_gen.sv
`default_nettype none
// ============================================================================
// Module      : tick_gen
// Description : Free-running divider producing a 1-cycle tick every DIV
//               cycles. While hold is high the count is parked at 0, so the
//               first tick after release comes DIV cycles later.
// Revision    : 1.0 - initial release
// ============================================================================
module tick_gen #(
    parameter int DIV = 4
) (
    input  wire  clk,
    input  wire  reset,
    input  wire  hold,
    output logic tick
);

    localparam int              c_cnt_w = (DIV > 1) ? $clog2(DIV) : 1;
    localparam logic [c_cnt_w-1:0] c_last = c_cnt_w'(DIV - 1);

    logic [c_cnt_w-1:0] count_q;
    logic [c_cnt_w-1:0] count_d;

    if (DIV < 2) begin : g_bad_div
        $error("tick_gen: DIV must be at least 2");
    end

    // Next count: park at 0 on hold, wrap after the last count
    always_comb begin
        count_d = count_q + 1'b1;
        if (hold || (count_q == c_last)) begin
            count_d = '0;
        end
    end

    // Count register
    always_ff @(posedge clk) begin
        if (reset) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

    assign tick = (count_q == c_last);

endmodule : tick_gen
`default_nettype wire

// File: rtl/bird_motion_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : bird_motion_ctrl
// Description : Conditions the raw flap key and produces the motion tick and
//               up/down direction level for the bird column cells. Freezes
//               bird motion on game over until reset.
//               Optional build macro DEBOUNCE_EN: accept a key level only
//               after DEB_CYCLES consecutive stable cycles.
// Revision    : 1.0 - initial release
// ============================================================================
module bird_motion_ctrl
    import flappy_pkg::*;
#(
    parameter int TICK_DIV   = TICK_DIV_DEF,
    parameter int FLAP_TICKS = FLAP_TICKS_DEF,
    parameter int DEB_CYCLES = DEB_CYCLES_DEF
) (
    input  wire                 clk,
    input  wire                 reset,
    bird_motion_ctrl_if.slave   bus
);

    localparam int                 c_rise_w = $clog2(FLAP_TICKS + 1);
    localparam logic [c_rise_w-1:0] c_reload = c_rise_w'(FLAP_TICKS);
    localparam logic [c_rise_w-1:0] c_one    = c_rise_w'(1);

    if (FLAP_TICKS < 1) begin : g_bad_flap_ticks
        $error("bird_motion_ctrl: FLAP_TICKS must be at least 1");
    end
    if (DEB_CYCLES < 1) begin : g_bad_deb_cycles
        $error("bird_motion_ctrl: DEB_CYCLES must be at least 1");
    end

    // ------------------------------------------------------------------
    // Key input path
    // ------------------------------------------------------------------
    logic sync1_q;
    logic sync2_q;
    logic w_key_lvl_n;   // conditioned key level, active-low
    logic w_key;
    logic key_prev_q;
    logic flap_q;

    // Two-stage synchronizer; resets to the released level
    always_ff @(posedge clk) begin
        if (reset) begin
            sync1_q <= 1'b1;
            sync2_q <= 1'b1;
        end else begin
            sync1_q <= bus.key_n;
            sync2_q <= sync1_q;
        end
    end

`ifdef DEBOUNCE_EN
    localparam int                c_deb_w    = $clog2(DEB_CYCLES + 1);
    localparam logic [c_deb_w-1:0] c_deb_last = c_deb_w'(DEB_CYCLES - 1);

    logic               deb_q;
    logic               deb_d;
    logic [c_deb_w-1:0] deb_cnt_q;
    logic [c_deb_w-1:0] deb_cnt_d;

    // Count cycles the synced level differs from the accepted one; any
    // return to the accepted level restarts the count
    always_comb begin
        deb_d     = deb_q;
        deb_cnt_d = '0;
        if (sync2_q != deb_q) begin
            if (deb_cnt_q == c_deb_last) begin
                deb_d     = sync2_q;
                deb_cnt_d = '0;
            end else begin
                deb_cnt_d = deb_cnt_q + 1'b1;
            end
        end
    end

    // Debounce registers
    always_ff @(posedge clk) begin
        if (reset) begin
            deb_q     <= 1'b1;
            deb_cnt_q <= '0;
        end else begin
            deb_q     <= deb_d;
            deb_cnt_q <= deb_cnt_d;
        end
    end

    assign w_key_lvl_n = deb_q;
`else
    assign w_key_lvl_n = sync2_q;
`endif

    assign w_key = ~w_key_lvl_n;

    // Press edge detect; flap is registered so a held key yields one pulse
    always_ff @(posedge clk) begin
        if (reset) begin
            key_prev_q <= 1'b0;
            flap_q     <= 1'b0;
        end else begin
            key_prev_q <= w_key;
            flap_q     <= w_key & ~key_prev_q;
        end
    end

    // ------------------------------------------------------------------
    // Motion tick
    // ------------------------------------------------------------------
    bird_state_t state_q;
    bird_state_t state_d;
    logic        w_tick;
    logic        w_hold;

    assign w_hold = (state_q == WAIT_START);

    tick_gen #(
        .DIV   (TICK_DIV)
    ) u_tick_gen (
        .clk   (clk),
        .reset (reset),
        .hold  (w_hold),
        .tick  (w_tick)
    );

    // ------------------------------------------------------------------
    // Motion FSM
    // ------------------------------------------------------------------
    logic [c_rise_w-1:0] rise_left_q;
    logic [c_rise_w-1:0] rise_left_d;
    logic                pending_q;
    logic                pending_d;
    logic                up_q;
    logic                up_d;

    // Next state, rise counter and pending flap; game over has top priority
    always_comb begin
        state_d     = state_q;
        rise_left_d = rise_left_q;
        pending_d   = pending_q;
        if (bus.game_over) begin
            state_d     = FROZEN;
            rise_left_d = '0;
            pending_d   = 1'b0;
        end else begin
            case (state_q)
                WAIT_START: begin
                    if (flap_q) begin
                        state_d     = RISE;
                        rise_left_d = c_reload;
                    end
                end
                RISE, FALL: begin
                    if (w_tick) begin
                        // A flap on the tick cycle is consumed here as well
                        pending_d = 1'b0;
                        if (pending_q || flap_q) begin
                            state_d     = RISE;
                            rise_left_d = c_reload;
                        end else if (state_q == RISE) begin
                            rise_left_d = rise_left_q - 1'b1;
                            if (rise_left_q == c_one) begin
                                state_d = FALL;
                            end
                        end
                    end else if (flap_q) begin
                        pending_d = 1'b1;
                    end
                end
                FROZEN: begin
                    state_d = FROZEN;
                end
                default: begin
                    state_d = WAIT_START;
                end
            endcase
        end
        up_d = (state_d == RISE);
    end

    // FSM state registers
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q     <= WAIT_START;
            rise_left_q <= '0;
            pending_q   <= 1'b0;
            up_q        <= 1'b0;
        end else begin
            state_q     <= state_d;
            rise_left_q <= rise_left_d;
            pending_q   <= pending_d;
            up_q        <= up_d;
        end
    end

    // In FROZEN the tick keeps running; the cells hold on game over themselves
    assign bus.enable = w_tick & (state_q != WAIT_START);
    assign bus.up     = up_q;
    assign bus.flap   = flap_q;

endmodule : bird_motion_ctrl
`default_nettype wire

// File: tb/tb_bird_motion_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : tb_bird_motion_ctrl
// Description : Directed self-checking bench for bird_motion_ctrl with
//               TICK_DIV=4, FLAP_TICKS=2, DEB_CYCLES=3.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_bird_motion_ctrl;

    logic clk;
    logic reset;
    int   n_vec;
    int   n_err;

    bird_motion_ctrl_if bus ();

    bird_motion_ctrl #(
        .TICK_DIV   (4),
        .FLAP_TICKS (2),
        .DEB_CYCLES (3)
    ) u_dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Advance one clock, then check all three outputs 1 time unit after the edge
    task automatic chk(input logic e_en, input logic e_up, input logic e_fl, input string tag);
        @(posedge clk);
        #1;
        n_vec++;
        assert (bus.enable === e_en) else begin
            n_err++;
            $error("FAIL %s enable got=%b exp=%b", tag, bus.enable, e_en);
        end
        n_vec++;
        assert (bus.up === e_up) else begin
            n_err++;
            $error("FAIL %s up got=%b exp=%b", tag, bus.up, e_up);
        end
        n_vec++;
        assert (bus.flap === e_fl) else begin
            n_err++;
            $error("FAIL %s flap got=%b exp=%b", tag, bus.flap, e_fl);
        end
    endtask

    task automatic run(input int n, input logic e_en, input logic e_up, input logic e_fl,
                       input string tag);
        for (int i = 0; i < n; i++) begin
            chk(e_en, e_up, e_fl, tag);
        end
    endtask

    initial begin
        n_vec         = 0;
        n_err         = 0;
        reset         = 1'b1;
        bus.key_n     = 1'b1;
        bus.game_over = 1'b0;

        // 1: reset and idle
        @(posedge clk);
        #1;
        chk(0, 0, 0, "t1_reset");
        reset = 1'b0;
        run(20, 0, 0, 0, "t1_idle");

`ifdef DEBOUNCE_EN
        // 6a: 2-cycle glitch is rejected
        bus.key_n = 1'b0;
        run(2, 0, 0, 0, "t6_glitch_low");
        bus.key_n = 1'b1;
        run(10, 0, 0, 0, "t6_glitch");

        // 6b: 5-cycle press accepted, flap 6 cycles after press
        bus.key_n = 1'b0;
        run(5, 0, 0, 0, "t6_deb_wait");
        bus.key_n = 1'b1;
        chk(0, 0, 1, "t6_flap");
        run(3, 0, 1, 0, "t6_rise");
        chk(1, 1, 0, "t6_en1");
`else
        // 2: 1-cycle press from idle
        bus.key_n = 1'b0;
        chk(0, 0, 0, "t2_sync1");
        bus.key_n = 1'b1;
        chk(0, 0, 0, "t2_sync2");
        chk(0, 0, 1, "t2_flap");
        run(3, 0, 1, 0, "t2_rise_a");
        chk(1, 1, 0, "t2_en1");
        run(3, 0, 1, 0, "t2_rise_b");
        chk(1, 1, 0, "t2_en2");
        run(3, 0, 0, 0, "t2_fall_a");
        chk(1, 0, 0, "t2_en3");
        run(3, 0, 0, 0, "t2_fall_b");
        chk(1, 0, 0, "t2_en4");

        // 3: key held 12 cycles from FALL; one flap, pending consumed at next tick
        bus.key_n = 1'b0;
        run(2, 0, 0, 0, "t3_sync");
        chk(0, 0, 1, "t3_flap");
        chk(1, 0, 0, "t3_en_pend");
        run(3, 0, 1, 0, "t3_rise_a");
        chk(1, 1, 0, "t3_en1");
        run(3, 0, 1, 0, "t3_rise_b");
        chk(1, 1, 0, "t3_en2");
        bus.key_n = 1'b1;
        run(3, 0, 0, 0, "t3_fall");
        chk(1, 0, 0, "t3_en3");

        // 4: re-flap during RISE before enable 2 extends the rise
        bus.key_n = 1'b0;
        chk(0, 0, 0, "t4_sync1");
        bus.key_n = 1'b1;
        chk(0, 0, 0, "t4_sync2");
        chk(0, 0, 1, "t4_flap1");
        chk(1, 0, 0, "t4_en_pend");
        run(3, 0, 1, 0, "t4_rise_a");
        chk(1, 1, 0, "t4_en1");
        bus.key_n = 1'b0;
        chk(0, 1, 0, "t4_re_sync1");
        bus.key_n = 1'b1;
        chk(0, 1, 0, "t4_re_sync2");
        chk(0, 1, 1, "t4_flap2");
        chk(1, 1, 0, "t4_en2_reload");
        run(3, 0, 1, 0, "t4_rise_b");
        chk(1, 1, 0, "t4_en3");
        run(3, 0, 1, 0, "t4_rise_c");
        chk(1, 1, 0, "t4_en4");
        run(3, 0, 0, 0, "t4_fall");
        chk(1, 0, 0, "t4_en5");

        // 5: game over on the flap cycle freezes motion
        bus.key_n = 1'b0;
        chk(0, 0, 0, "t5_sync1");
        bus.key_n = 1'b1;
        chk(0, 0, 0, "t5_sync2");
        chk(0, 0, 1, "t5_flap");
        bus.game_over = 1'b1;
        chk(1, 0, 0, "t5_frozen_en");
        bus.key_n = 1'b0;
        chk(0, 0, 0, "t5_fz_sync1");
        bus.key_n = 1'b1;
        chk(0, 0, 0, "t5_fz_sync2");
        chk(0, 0, 1, "t5_fz_flap");
        chk(1, 0, 0, "t5_fz_en");
        bus.game_over = 1'b0;
        bus.key_n     = 1'b0;
        chk(0, 0, 0, "t5_fz2_sync1");
        bus.key_n = 1'b1;
        chk(0, 0, 0, "t5_fz2_sync2");
        chk(0, 0, 1, "t5_fz2_flap");
        chk(1, 0, 0, "t5_fz2_en");
        run(3, 0, 0, 0, "t5_fz2_hold");
        chk(1, 0, 0, "t5_fz2_en2");
        reset = 1'b1;
        chk(0, 0, 0, "t5_reset");
        reset = 1'b0;
        run(10, 0, 0, 0, "t5_wait_start");
`endif

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule : tb_bird_motion_ctrl
`default_nettype wire
